// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port synchronous framebuffer RAM between the
// display pixel fetch (absolute priority) and a buffered drawing/CPU writer.
// Optional feature macro: FB_ARB_STALL_CNT_EN (writer stall counter on stall_cnt).
module vga_fb_arbiter #(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned DATA_W     = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_idle,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stall_cnt
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_DISP, ST_WRITE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  state_t            state_q, state_d;
  wr_entry_t         fifo_mem [FIFO_DEPTH];
  wr_entry_t         head_c;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_c, pop_c, fifo_empty_c;
  logic              mem_en_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              rd_inflight_q;

  assign fifo_empty_c = (count_q == '0);
  assign push_c       = wr_valid & wr_ready;
  assign pop_c        = (state_d == ST_WRITE);
  assign head_c       = fifo_mem[rd_ptr_q];

  // Grant state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next grant: display first, then drain the write buffer
  always_comb begin
    state_d = ST_IDLE;
    if (disp_req)           state_d = ST_DISP;
    else if (!fifo_empty_c) state_d = ST_WRITE;
  end

  // RAM command for the granted access; address/data hold when idle
  always_comb begin
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    case (state_d)
      ST_DISP: begin
        mem_en_d   = 1'b1;
        mem_addr_d = disp_addr;
      end
      ST_WRITE: begin
        mem_en_d    = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = head_c.addr;
        mem_wdata_d = head_c.data;
      end
      default: ;
    endcase
  end

  // Occupancy after this edge's push/pop
  always_comb begin
    count_d = count_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: ;
    endcase
  end

  // Write buffer pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Write buffer storage (contents are don't-care while empty)
  always_ff @(posedge clk) begin
    if (push_c) fifo_mem[wr_ptr_q] <= {wr_addr, wr_data};
  end

  // Registered RAM command, writer handshake and display return path
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_en        <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      wr_ready      <= 1'b1;
      wr_idle       <= 1'b1;
      rd_inflight_q <= 1'b0;
      disp_valid    <= 1'b0;
      disp_data     <= '0;
    end else begin
      mem_en        <= mem_en_d;
      mem_we        <= mem_we_d;
      mem_addr      <= mem_addr_d;
      mem_wdata     <= mem_wdata_d;
      wr_ready      <= (count_d != DEPTH_C);
      wr_idle       <= (count_d == '0) && (state_d != ST_WRITE);
      rd_inflight_q <= (state_q == ST_DISP);
      disp_valid    <= rd_inflight_q;
      if (rd_inflight_q) disp_data <= mem_rdata;
    end
  end

`ifdef FB_ARB_STALL_CNT_EN
  logic [15:0] stall_q;

  // Saturating count of edges where the writer is held off
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else if (wr_valid && !wr_ready && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule
